// File: rtl/alu_arbiter.sv
// Two-port valid/ready arbiter sharing one ALU; a LATENCY-deep tag pipe routes each result back to its issuer.
// Tie-break is fixed priority to port 0 unless ALU_ARB_ROUND_ROBIN_EN is defined.
module alu_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int CTRL_WIDTH   = 4,
  parameter int SHAMT_WIDTH  = 5,
  parameter int STATUS_WIDTH = 4,
  parameter int LATENCY      = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [1:0]                req_valid,
  output logic [1:0]                req_ready,
  input  logic [2*DATA_WIDTH-1:0]   req_a,
  input  logic [2*DATA_WIDTH-1:0]   req_b,
  input  logic [2*CTRL_WIDTH-1:0]   req_ctrl,
  input  logic [2*SHAMT_WIDTH-1:0]  req_shamt,
  output logic [2*DATA_WIDTH-1:0]   alu_dataIn,
  output logic [CTRL_WIDTH-1:0]     alu_ctrl,
  output logic [SHAMT_WIDTH-1:0]    alu_shamt,
  output logic                      alu_en_n,
  input  logic [DATA_WIDTH-1:0]     alu_dataOut,
  input  logic [STATUS_WIDTH-1:0]   alu_status,
  input  logic [DATA_WIDTH-1:0]     alu_hi,
  input  logic [DATA_WIDTH-1:0]     alu_lo,
  output logic [1:0]                rsp_valid,
  output logic [DATA_WIDTH-1:0]     rsp_data,
  output logic [STATUS_WIDTH-1:0]   rsp_status,
  output logic [DATA_WIDTH-1:0]     rsp_hi,
  output logic [DATA_WIDTH-1:0]     rsp_lo,
  output logic                      busy
);

  logic                    iss_vld_q, iss_vld_d;
  logic                    iss_port_q, iss_port_d;
  logic [DATA_WIDTH-1:0]   alu_a_q, alu_a_d;
  logic [DATA_WIDTH-1:0]   alu_b_q, alu_b_d;
  logic [CTRL_WIDTH-1:0]   alu_ctrl_q, alu_ctrl_d;
  logic [SHAMT_WIDTH-1:0]  alu_shamt_q, alu_shamt_d;
  logic [LATENCY-1:0]      tag_vld_q, tag_vld_d;
  logic [LATENCY-1:0]      tag_port_q, tag_port_d;
  logic [1:0]              rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic [STATUS_WIDTH-1:0] rsp_status_q, rsp_status_d;
  logic [DATA_WIDTH-1:0]   rsp_hi_q, rsp_hi_d;
  logic [DATA_WIDTH-1:0]   rsp_lo_q, rsp_lo_d;
  logic                    accept;
  logic                    grant_port;
`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic                    rr_last_q, rr_last_d;
`endif

  // Grant is purely a function of the valids and the tie-break state, held off while in reset.
  always_comb begin
    req_ready = 2'b00;
    if (rst_n) begin
      if (req_valid == 2'b11) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
        req_ready = rr_last_q ? 2'b01 : 2'b10;
`else
        req_ready = 2'b01;
`endif
      end else begin
        req_ready = req_valid;
      end
    end
  end

  assign accept     = |(req_valid & req_ready);
  assign grant_port = req_ready[1];

  always_comb begin
    iss_vld_d   = accept;
    iss_port_d  = grant_port;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_ctrl_d  = alu_ctrl_q;
    alu_shamt_d = alu_shamt_q;
    if (accept) begin
      alu_a_d     = grant_port ? req_a[2*DATA_WIDTH-1:DATA_WIDTH] : req_a[DATA_WIDTH-1:0];
      alu_b_d     = grant_port ? req_b[2*DATA_WIDTH-1:DATA_WIDTH] : req_b[DATA_WIDTH-1:0];
      alu_ctrl_d  = grant_port ? req_ctrl[2*CTRL_WIDTH-1:CTRL_WIDTH] : req_ctrl[CTRL_WIDTH-1:0];
      alu_shamt_d = grant_port ? req_shamt[2*SHAMT_WIDTH-1:SHAMT_WIDTH]
                               : req_shamt[SHAMT_WIDTH-1:0];
    end

    // The tag enters one cycle after issue, so its exit lines up with valid ALU outputs.
    tag_vld_d  = LATENCY'({tag_vld_q, iss_vld_q});
    tag_port_d = LATENCY'({tag_port_q, iss_port_q});

    rsp_valid_d  = {tag_port_q[LATENCY-1], ~tag_port_q[LATENCY-1]} & {2{tag_vld_q[LATENCY-1]}};
    rsp_data_d   = rsp_data_q;
    rsp_status_d = rsp_status_q;
    rsp_hi_d     = rsp_hi_q;
    rsp_lo_d     = rsp_lo_q;
    if (tag_vld_q[LATENCY-1]) begin
      rsp_data_d   = alu_dataOut;
      rsp_status_d = alu_status;
      rsp_hi_d     = alu_hi;
      rsp_lo_d     = alu_lo;
    end
`ifdef ALU_ARB_ROUND_ROBIN_EN
    rr_last_d = accept ? grant_port : rr_last_q;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_vld_q    <= 1'b0;
      iss_port_q   <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_ctrl_q   <= '0;
      alu_shamt_q  <= '0;
      tag_vld_q    <= '0;
      tag_port_q   <= '0;
      rsp_valid_q  <= 2'b00;
      rsp_data_q   <= '0;
      rsp_status_q <= '0;
      rsp_hi_q     <= '0;
      rsp_lo_q     <= '0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
      rr_last_q    <= 1'b1;
`endif
    end else begin
      iss_vld_q    <= iss_vld_d;
      iss_port_q   <= iss_port_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_ctrl_q   <= alu_ctrl_d;
      alu_shamt_q  <= alu_shamt_d;
      tag_vld_q    <= tag_vld_d;
      tag_port_q   <= tag_port_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_status_q <= rsp_status_d;
      rsp_hi_q     <= rsp_hi_d;
      rsp_lo_q     <= rsp_lo_d;
`ifdef ALU_ARB_ROUND_ROBIN_EN
      rr_last_q    <= rr_last_d;
`endif
    end
  end

  assign alu_dataIn = {alu_a_q, alu_b_q};
  assign alu_ctrl   = alu_ctrl_q;
  assign alu_shamt  = alu_shamt_q;
  assign alu_en_n   = ~iss_vld_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_status = rsp_status_q;
  assign rsp_hi     = rsp_hi_q;
  assign rsp_lo     = rsp_lo_q;
  assign busy       = iss_vld_q | (|tag_vld_q);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one LATENCY=1 and one LATENCY=3 instance share stimulus, each fed by a behavioural ALU.
module tb_alu_arbiter;

  typedef struct packed {
    logic [3:0]  st;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] dat;
  } alu_res_t;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [63:0] req_a, req_b;
  logic [7:0]  req_ctrl;
  logic [9:0]  req_shamt;

  logic [1:0]  rdy1, rv1, rdy3, rv3;
  logic [63:0] din1, din3;
  logic [3:0]  ctrl1, ctrl3, rs1, rs3;
  logic [4:0]  shamt1, shamt3;
  logic        en_n1, en_n3, busy1, busy3;
  logic [31:0] rd1, rh1, rl1, rd3, rh3, rl3;

  alu_res_t m1_q;
  alu_res_t m3_q [3];

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.LATENCY(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(rdy1),
    .req_a(req_a), .req_b(req_b), .req_ctrl(req_ctrl), .req_shamt(req_shamt),
    .alu_dataIn(din1), .alu_ctrl(ctrl1), .alu_shamt(shamt1), .alu_en_n(en_n1),
    .alu_dataOut(m1_q.dat), .alu_status(m1_q.st), .alu_hi(m1_q.hi), .alu_lo(m1_q.lo),
    .rsp_valid(rv1), .rsp_data(rd1), .rsp_status(rs1), .rsp_hi(rh1), .rsp_lo(rl1),
    .busy(busy1)
  );

  alu_arbiter #(.LATENCY(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(rdy3),
    .req_a(req_a), .req_b(req_b), .req_ctrl(req_ctrl), .req_shamt(req_shamt),
    .alu_dataIn(din3), .alu_ctrl(ctrl3), .alu_shamt(shamt3), .alu_en_n(en_n3),
    .alu_dataOut(m3_q[2].dat), .alu_status(m3_q[2].st), .alu_hi(m3_q[2].hi), .alu_lo(m3_q[2].lo),
    .rsp_valid(rv3), .rsp_data(rd3), .rsp_status(rs3), .rsp_hi(rh3), .rsp_lo(rl3),
    .busy(busy3)
  );

  function automatic alu_res_t alu_model(input logic [63:0] din, input logic [3:0] op,
                                         input logic [4:0] sh);
    logic [31:0] a, b;
    logic [63:0] p;
    logic [32:0] s;
    alu_res_t    r;
    a = din[63:32];
    b = din[31:0];
    p = 64'(a) * 64'(b);
    s = 33'(a) + 33'(b);
    r = '0;
    case (op)
      4'h0: r.dat = a & b;
      4'h1: r.dat = a | b;
      4'h4: begin
        r.dat   = s[31:0];
        r.st[2] = s[32];
        r.st[3] = (a[31] == b[31]) && (s[31] != a[31]);
      end
      4'h6: begin
        r.dat = p[31:0];
        r.hi  = p[63:32];
        r.lo  = p[31:0];
      end
      4'h8:    r.dat = a << sh;
      default: r.dat = '0;
    endcase
    r.st[0] = (r.dat == 32'h0);
    r.st[1] = r.dat[31];
    return r;
  endfunction

  always @(posedge clk) begin
    m1_q    <= alu_model(din1, ctrl1, shamt1);
    m3_q[0] <= alu_model(din3, ctrl3, shamt3);
    m3_q[1] <= m3_q[0];
    m3_q[2] <= m3_q[1];
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] c, input logic [4:0] s);
    req_a[p*32 +: 32]    = a;
    req_b[p*32 +: 32]    = b;
    req_ctrl[p*4 +: 4]   = c;
    req_shamt[p*5 +: 5]  = s;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = 2'b00;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [1:0] g [4];
    rst_n     = 1'b0;
    req_valid = 2'b11;
    req_a     = '0;
    req_b     = '0;
    req_ctrl  = '0;
    req_shamt = '0;
    #2;
    chk("rst_ready", 64'(rdy1), 64'(2'b00));
    chk("rst_en_n", 64'(en_n1), 64'(1'b1));
    chk("rst_din", din1, 64'h0);
    chk("rst_ctrl", 64'(ctrl1), 64'h0);
    chk("rst_shamt", 64'(shamt1), 64'h0);
    chk("rst_rv", 64'(rv1), 64'h0);
    chk("rst_rsp", {rd1, rh1}, 64'h0);
    chk("rst_rsp_lo_st", {28'h0, rs1, rl1}, 64'h0);
    chk("rst_busy", 64'(busy1), 64'h0);
    req_valid = 2'b00;
    tick();
    rst_n = 1'b1;
    tick();

    // Single add from port 0
    set_port(0, 32'd5, 32'd3, 4'h4, 5'd7);
    req_valid = 2'b01;
    #1 chk("add_ready", 64'(rdy1), 64'(2'b01));
    tick();
    req_valid = 2'b00;
    chk("add_en_n_issue", 64'(en_n1), 64'(1'b0));
    chk("add_din", din1, 64'h0000_0005_0000_0003);
    chk("add_ctrl", 64'(ctrl1), 64'h4);
    chk("add_shamt", 64'(shamt1), 64'h7);
    chk("add_busy_issue", 64'(busy1), 64'h1);
    chk("add_rv_issue", 64'(rv1), 64'h0);
    tick();
    chk("add_en_n_after", 64'(en_n1), 64'(1'b1));
    chk("add_rv_early", 64'(rv1), 64'h0);
    chk("add_busy_tag", 64'(busy1), 64'h1);
    tick();
    chk("add_rv", 64'(rv1), 64'(2'b01));
    chk("add_data", 64'(rd1), 64'd8);
    chk("add_status", 64'(rs1), 64'h0);
    chk("add_busy_done", 64'(busy1), 64'h0);
    tick();
    chk("add_rv_pulse", 64'(rv1), 64'h0);
    chk("add_data_hold", 64'(rd1), 64'd8);
    chk("add_din_hold", din1, 64'h0000_0005_0000_0003);

    // Multiply from port 1
    set_port(1, 32'h1_0000, 32'h1_0000, 4'h6, 5'd0);
    req_valid = 2'b10;
    #1 chk("mul_ready", 64'(rdy1), 64'(2'b10));
    tick();
    req_valid = 2'b00;
    tick();
    tick();
    chk("mul_rv", 64'(rv1), 64'(2'b10));
    chk("mul_hi", 64'(rh1), 64'h1);
    chk("mul_lo", 64'(rl1), 64'h0);
    chk("mul_data", 64'(rd1), 64'h0);
    chk("mul_zero", 64'(rs1[0]), 64'h1);

    // Contention: port 0 ANDs, port 1 ORs the same operands
    do_reset();
    set_port(0, 32'hF0, 32'h3C, 4'h0, 5'd0);
    set_port(1, 32'hF0, 32'h3C, 4'h1, 5'd0);
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      g[k] = (RR && k[0]) ? 2'b10 : 2'b01;
      #1 chk("cont_ready", 64'(rdy1), 64'(g[k]));
      tick();
      if (k >= 2) begin
        chk("cont_rv", 64'(rv1), 64'(g[k-2]));
        chk("cont_data", 64'(rd1), (g[k-2] == 2'b10) ? 64'hFC : 64'h30);
      end else begin
        chk("cont_rv_idle", 64'(rv1), 64'h0);
      end
    end
    req_valid = RR ? 2'b00 : 2'b10;
    #1 chk("cont_ready_tail", 64'(rdy1), RR ? 64'h0 : 64'(2'b10));
    tick();
    req_valid = 2'b00;
    chk("cont_rv", 64'(rv1), 64'(g[2]));
    tick();
    chk("cont_rv", 64'(rv1), 64'(g[3]));
    chk("cont_data", 64'(rd1), (g[3] == 2'b10) ? 64'hFC : 64'h30);
    tick();
    chk("cont_rv_tail", 64'(rv1), RR ? 64'h0 : 64'(2'b10));

    // Streaming into the LATENCY=3 instance
    do_reset();
    for (int k = 0; k < 11; k++) begin
      if (k < 6) begin
        set_port(0, 32'h100, 32'(k), 4'h4, 5'd0);
        req_valid = 2'b01;
      end else begin
        req_valid = 2'b00;
      end
      tick();
      chk("strm_busy", 64'(busy3), 64'(k <= 8));
      chk("strm_rv", 64'(rv3), (k >= 4 && k <= 9) ? 64'(2'b01) : 64'h0);
      if (k >= 4 && k <= 9) chk("strm_data", 64'(rd3), 64'(32'h100 + 32'(k - 4)));
    end

    // Reset while two operations are in flight
    do_reset();
    set_port(0, 32'd1, 32'd2, 4'h4, 5'd0);
    req_valid = 2'b01;
    tick();
    set_port(0, 32'd3, 32'd4, 4'h4, 5'd0);
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_ready", 64'(rdy1), 64'h0);
    chk("mid_en_n", 64'(en_n1), 64'h1);
    chk("mid_busy", 64'(busy1), 64'h0);
    chk("mid_busy3", 64'(busy3), 64'h0);
    chk("mid_din", din1, 64'h0);
    chk("mid_rv", 64'(rv1), 64'h0);
    req_valid = 2'b00;
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("mid_rv_after", {62'h0, rv1 | rv3}, 64'h0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port arbiter and sequencer that shares a single `alu` instance between two requesters, such as an issue stage and a branch/compare unit. It accepts operations over a valid/ready handshake and arbitrates between the ports each cycle. It drives the ALU operand, control and enable inputs, tracks every in-flight operation through a tag pipeline matched to the ALU's output latency, and routes each registered result back to the port that issued it.

## Interface
Parameters:
- `DATA_WIDTH`, 32: operand and result width.
- `CTRL_WIDTH`, 4: ALU opcode width.
- `SHAMT_WIDTH`, 5: shift amount width.
- `STATUS_WIDTH`, 4: ALU status width (zero, sign, carry, overflow).
- `LATENCY`, 1: cycles from the ALU input cycle to the cycle in which ALU outputs are valid; legal range is 1..8.

Ports (index i = requester 0/1; vector buses are packed with port 0 in the low slice):
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `req_valid`, in, 2: request valid per port.
- `req_ready`, out, 2: grant per port; combinational from `req_valid` and arbiter state.
- `req_a`, in, 2*DATA_WIDTH: first operand per port.
- `req_b`, in, 2*DATA_WIDTH: second operand per port.
- `req_ctrl`, in, 2*CTRL_WIDTH: opcode per port.
- `req_shamt`, in, 2*SHAMT_WIDTH: shift amount per port.
- `alu_dataIn`, out, 2*DATA_WIDTH: `{a, b}`; a is in the upper half.
- `alu_ctrl`, out, CTRL_WIDTH: opcode to the ALU.
- `alu_shamt`, out, SHAMT_WIDTH: shift amount to the ALU.
- `alu_en_n`, out, 1: active-low ALU enable; low only in an issue cycle.
- `alu_dataOut`, in, DATA_WIDTH: ALU result.
- `alu_status`, in, STATUS_WIDTH: ALU status flags.
- `alu_hi`, in, DATA_WIDTH: ALU multiply high word.
- `alu_lo`, in, DATA_WIDTH: ALU multiply low word.
- `rsp_valid`, out, 2: one-hot response strobe, one cycle per operation.
- `rsp_data`, out, DATA_WIDTH: result, shared by both ports.
- `rsp_status`, out, STATUS_WIDTH: status, shared by both ports.
- `rsp_hi`, out, DATA_WIDTH: multiply high word, shared by both ports.
- `rsp_lo`, out, DATA_WIDTH: multiply low word, shared by both ports.
- `busy`, out, 1: high while any operation is in flight.

## Operation
- Acceptance: port i is accepted at an edge where `req_valid[i] && req_ready[i]`.
- Grant rules:
  - At most one bit of `req_ready` is high per cycle.
  - `req_ready[i]` is never high unless `req_valid[i]` is high.
  - With exactly one port valid, that port is granted.
- Arbitration when both ports are valid: see Configuration.
- Issue register: on acceptance, the granted operands, ctrl and shamt are registered onto the `alu_*` outputs, and `alu_en_n` is driven 0 for the following cycle (the issue cycle I).
  - With no acceptance, `alu_en_n` is 1 and the `alu_*` data outputs hold their last values.
- Tag pipeline: a LATENCY-deep shift register of {valid, port id} entries, advanced every cycle.
  - When an entry exits, `alu_dataOut`, `alu_status`, `alu_hi` and `alu_lo` are registered onto the `rsp_*` buses, and the matching `rsp_valid` bit pulses for one cycle.
  - Otherwise `rsp_valid` is 0 and the `rsp_*` data buses hold their last values.
- Responses have no backpressure; requesters must consume a response in the cycle `rsp_valid` is high.
- `busy` = OR of all tag-pipeline valid bits and the issue-stage valid bit.
- Width rules:
  - Operands pass through unmodified.
  - `rsp_hi` and `rsp_lo` are forwarded for every opcode; their content is meaningful only for the multiply opcode (0x6).
- Reset (`rst_n` = 0, asynchronous):
  - Outputs: `req_ready` = 0, `alu_en_n` = 1, `alu_dataIn`/`alu_ctrl`/`alu_shamt` = 0, `rsp_valid` = 0, all `rsp_*` data = 0, `busy` = 0.
  - State: all tags are invalid and the round-robin pointer selects port 0 first.
  - Reset mid-operation discards all in-flight operations; no `rsp_valid` is produced for them after reset release.

## Timing
- Acceptance at edge E0 → issue cycle between E0 and E0+1, with `alu_en_n` = 0.
- ALU outputs are sampled at edge E0+LATENCY+1.
- `rsp_valid` is high between edges E0+LATENCY+1 and E0+LATENCY+2.
- Total latency from acceptance to response = LATENCY+1 cycles.
- Throughput is one acceptance per cycle; back-to-back operations from either port produce back-to-back responses in issue order.
- Responses are strictly in order; no two `rsp_valid` pulses occur in the same cycle.
- Simultaneous events: an acceptance and a response in the same cycle are independent and both occur.
- `req_ready` has no dependency on `rsp_*` or `busy`.

## Configuration
- Macro `ALU_ARB_ROUND_ROBIN_EN`.
- Defined: round-robin arbitration.
  - When both ports are valid, grant goes to the port not granted most recently.
  - The pointer updates only on an acceptance; after reset, port 0 wins the first tie.
- Undefined: fixed priority; port 0 always wins a tie, and the pointer logic is not built.

## Test plan
- Single op, LATENCY=1: port 0 sends a=5, b=3, ctrl=0x4 → `alu_en_n` low one cycle later; `rsp_valid` = 2'b01 two cycles after acceptance; `rsp_data` = 8, `rsp_status` = 4'b0000.
- Contention with round-robin enabled: both ports valid for 4 cycles (port 0 ctrl=0x0, port 1 ctrl=0x1) → grants 0,1,0,1; `rsp_valid` = 01,10,01,10 on consecutive cycles.
- Contention, macro undefined: same stimulus → 4 grants to port 0; port 1 is not granted until port 0 drops valid.
- Multiply: port 1 sends a=0x10000, b=0x10000, ctrl=0x6 → `rsp_valid` = 2'b10, `rsp_hi` = 1, `rsp_lo` = 0, `rsp_data` = 0, `rsp_status[0]` = 1.
- LATENCY=3 streaming: 6 consecutive port 0 ops (b = 0..5) → 6 consecutive `rsp_valid` pulses, in order, starting 4 cycles after the first acceptance; `busy` is high throughout.
- Reset mid-flight: assert `rst_n` = 0 one cycle after 2 acceptances → all outputs take reset values immediately; no `rsp_valid` follows after release.
